// File: rtl/fft5_butterfly_pkg.sv
// Shared definitions for the FFT stage butterflies: default widths,
// twiddle scaling and the saturation helper used by every stage.
package fft5_butterfly_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int TW_DEFAULT = 12;

    // Twiddles are Q7: 127 represents roughly 1.0.
    localparam int TW_SHIFT = 7;

    // Working width for the saturation helper, wide enough for any stage.
    localparam int SAT_W = 64;

    // Clamp a wide signed value to the range of a dw-bit signed number.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] x,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fft5_cmul.sv
// Registered complex multiplier: bw = (b * w) >>> TW_SHIFT, one pipeline
// stage, advancing only when en is high. Truncation is toward -infinity.
module fft5_cmul
    import fft5_butterfly_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int TW = TW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW+TW:0] bw_re,
    output logic signed [DW+TW:0] bw_im
);

    localparam int MW = DW + TW;
    localparam int PW = DW + TW + 1;

    logic signed [MW-1:0] br_x, bi_x, wr_x, wi_x;
    logic signed [MW-1:0] rr, ii, ri, ir;
    logic signed [PW-1:0] p_re, p_im;

    // Sign-extend the operands, form the four partial products and combine
    // them one bit wider so the sum/difference can never wrap.
    always_comb begin
        br_x = {{TW{b_re[DW-1]}}, b_re};
        bi_x = {{TW{b_im[DW-1]}}, b_im};
        wr_x = {{DW{w_re[TW-1]}}, w_re};
        wi_x = {{DW{w_im[TW-1]}}, w_im};
        rr   = br_x * wr_x;
        ii   = bi_x * wi_x;
        ri   = br_x * wi_x;
        ir   = bi_x * wr_x;
        p_re = {rr[MW-1], rr} - {ii[MW-1], ii};
        p_im = {ri[MW-1], ri} + {ir[MW-1], ir};
    end

    // Register the rescaled product; holds while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bw_re <= '0;
            bw_im <= '0;
        end else if (en) begin
            bw_re <= p_re >>> TW_SHIFT;
            bw_im <= p_im >>> TW_SHIFT;
        end
    end

endmodule

// File: rtl/fft5_butterfly.sv
// Radix-2 DIT butterfly for FFT stage 5: y0 = a + b*w, y1 = a - b*w.
// Three register stages (capture, multiply, combine) under one global
// enable so downstream backpressure freezes the whole pipeline.
module fft5_butterfly
    import fft5_butterfly_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int TW    = TW_DEFAULT,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im,
    output logic                 sat_flag
);

    localparam int PW = DW + TW + 1;
    localparam int SW = DW + TW + 2;

    logic                 en;
    logic                 v1, v2;
    logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
    logic signed [TW-1:0] w1_re, w1_im;
    logic signed [DW-1:0] a2_re, a2_im;
    logic signed [PW-1:0] bw_re, bw_im;
    logic [DW:0]          c0_re, c0_im, c1_re, c1_im;
    logic                 any_clamp;

    // The only thing that can stop the pipeline is a held output beat.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // a +/- bw at full width, optionally halved before saturation.
    function automatic logic signed [SW-1:0] combine(
        input logic signed [DW-1:0] a,
        input logic signed [PW-1:0] bw,
        input logic                 neg
    );
        logic signed [SW-1:0] ax;
        logic signed [SW-1:0] bx;
        logic signed [SW-1:0] r;
        ax = {{(SW-DW){a[DW-1]}}, a};
        bx = {{(SW-PW){bw[PW-1]}}, bw};
        r  = neg ? (ax - bx) : (ax + bx);
        if (SCALE != 0) begin
            r = r >>> 1;
        end
        return r;
    endfunction

    // Returns {clamped, value} so the caller can track saturation events.
    function automatic logic [DW:0] clamp_to_dw(input logic signed [SW-1:0] r);
        logic signed [SAT_W-1:0] wide;
        logic signed [SAT_W-1:0] lim;
        wide = {{(SAT_W-SW){r[SW-1]}}, r};
        lim  = saturate(wide, DW);
        return {lim != wide, lim[DW-1:0]};
    endfunction

    // S1: capture operands and twiddle; data loads on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            a1_re <= '0;
            a1_im <= '0;
            b1_re <= '0;
            b1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
        end else if (en) begin
            v1    <= in_valid;
            a1_re <= a_re;
            a1_im <= a_im;
            b1_re <= b_re;
            b1_im <= b_im;
            w1_re <= tw_re;
            w1_im <= tw_im;
        end
    end

    fft5_cmul #(
        .DW(DW),
        .TW(TW)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .b_re  (b1_re),
        .b_im  (b1_im),
        .w_re  (w1_re),
        .w_im  (w1_im),
        .bw_re (bw_re),
        .bw_im (bw_im)
    );

    // S2: carry a and the valid bit alongside the multiplier stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            a2_re <= '0;
            a2_im <= '0;
        end else if (en) begin
            v2    <= v1;
            a2_re <= a1_re;
            a2_im <= a1_im;
        end
    end

    // S3 datapath: sum/difference per component, then saturate.
    always_comb begin
        c0_re     = clamp_to_dw(combine(a2_re, bw_re, 1'b0));
        c0_im     = clamp_to_dw(combine(a2_im, bw_im, 1'b0));
        c1_re     = clamp_to_dw(combine(a2_re, bw_re, 1'b1));
        c1_im     = clamp_to_dw(combine(a2_im, bw_im, 1'b1));
        any_clamp = c0_re[DW] | c0_im[DW] | c1_re[DW] | c1_im[DW];
    end

    // S3 register: outputs, output valid and the sticky saturation flag,
    // which only counts clamps on real (valid) beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y0_re     <= '0;
            y0_im     <= '0;
            y1_re     <= '0;
            y1_im     <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            y0_re     <= c0_re[DW-1:0];
            y0_im     <= c0_im[DW-1:0];
            y1_re     <= c1_re[DW-1:0];
            y1_im     <= c1_im[DW-1:0];
            if (v2 && any_clamp) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft5_butterfly.sv
// Bench for fft5_butterfly: two instances (SCALE=0 and SCALE=1) share the
// stimulus; a queue per instance holds the expected beats in order.
module tb_fft5_butterfly;

    localparam int DW = 16;
    localparam int TW = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] tw_re, tw_im;

    logic in_ready0, out_valid0, sat0;
    logic signed [DW-1:0] y0_re0, y0_im0, y1_re0, y1_im0;
    logic in_ready1, out_valid1, sat1;
    logic signed [DW-1:0] y0_re1, y0_im1, y1_re1, y1_im1;

    typedef struct {
        int a_re, a_im, b_re, b_im, w_re, w_im;
        int y0r, y0i, y1r, y1i;
        int z0r, z0i, z1r, z1i;
    } vec_t;

    typedef struct {
        int y0r, y0i, y1r, y1i;
    } res_t;

    vec_t vecs[6];
    res_t q0[$];
    res_t q1[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fft5_butterfly #(.DW(DW), .TW(TW), .SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid0), .out_ready(out_ready),
        .y0_re(y0_re0), .y0_im(y0_im0), .y1_re(y1_re0), .y1_im(y1_im0),
        .sat_flag(sat0)
    );

    fft5_butterfly #(.DW(DW), .TW(TW), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid1), .out_ready(out_ready),
        .y0_re(y0_re1), .y0_im(y0_im1), .y1_re(y1_re1), .y1_im(y1_im1),
        .sat_flag(sat1)
    );

    function automatic int satModel(input longint x, input int scale);
        longint r;
        r = (scale != 0) ? (x >>> 1) : x;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic res_t model(input vec_t v, input int scale);
        longint pr, pi, br, bi;
        res_t   r;
        pr = longint'(v.b_re) * v.w_re - longint'(v.b_im) * v.w_im;
        pi = longint'(v.b_re) * v.w_im + longint'(v.b_im) * v.w_re;
        br = pr >>> 7;
        bi = pi >>> 7;
        r.y0r = satModel(longint'(v.a_re) + br, scale);
        r.y0i = satModel(longint'(v.a_im) + bi, scale);
        r.y1r = satModel(longint'(v.a_re) - br, scale);
        r.y1i = satModel(longint'(v.a_im) - bi, scale);
        return r;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int which, input int g0r, input int g0i,
                               input int g1r, input int g1i);
        res_t e;
        n_vec++;
        if (which == 0 ? q0.size() == 0 : q1.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL beat%0d: unexpected output (%0d,%0d)/(%0d,%0d)",
                     which, g0r, g0i, g1r, g1i);
            return;
        end
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        if (g0r != e.y0r || g0i != e.y0i || g1r != e.y1r || g1i != e.y1i) begin
            n_bad++;
            $display("[TB] FAIL beat%0d: got y0=(%0d,%0d) y1=(%0d,%0d), required y0=(%0d,%0d) y1=(%0d,%0d)",
                     which, g0r, g0i, g1r, g1i, e.y0r, e.y0i, e.y1r, e.y1i);
        end
    endtask

    // Drive one operand set from a negedge and hold it until accepted;
    // expected results are queued for the edge that takes it.
    task automatic applyStimulus(input vec_t v, input res_t e0, input res_t e1);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        a_re  = DW'(v.a_re);
        a_im  = DW'(v.a_im);
        b_re  = DW'(v.b_re);
        b_im  = DW'(v.b_im);
        tw_re = TW'(v.w_re);
        tw_im = TW'(v.w_im);
        for (int t = 0; t < 20 && !done; t++) begin
            if (in_ready0) begin
                q0.push_back(e0);
                q1.push_back(e1);
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) checkValue("accept_timeout", 0, 1);
    endtask

    task automatic applyVec(input vec_t v);
        res_t e0, e1;
        e0 = '{v.y0r, v.y0i, v.y1r, v.y1i};
        e1 = '{v.z0r, v.z0i, v.z1r, v.z1i};
        applyStimulus(v, e0, e1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) checkValue("drain_timeout", q0.size() + q1.size(), 0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: compare every beat that transfers out.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready === 1'b1) begin
            if (out_valid0) checkOutput(0, int'(y0_re0), int'(y0_im0), int'(y1_re0), int'(y1_im0));
            if (out_valid1) checkOutput(1, int'(y0_re1), int'(y0_im1), int'(y1_re1), int'(y1_im1));
        end
    end

    initial begin
        vec_t v;
        logic [4*DW:0] cap;
        int seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;

        // fields: a, b, w, expected SCALE=0 y0/y1, expected SCALE=1 y0/y1
        vecs[0] = '{100, 0, 64, 0, 127, 0,      163, 0, 37, 0,        81, 0, 18, 0};
        vecs[1] = '{100, 0, 64, 0, 0, -127,     100, -64, 100, 64,    50, -32, 50, 32};
        vecs[2] = '{32767, 0, 32767, 0, 127, 0, 32767, 0, 256, 0,     32639, 0, 128, 0};
        vecs[3] = '{-200, 50, 10, -20, 90, 90,  -179, 42, -221, 58,   -90, 21, -111, 29};
        vecs[4] = '{-32768, 0, 32767, 0, -127, 0, -32768, 0, -256, 0, -32640, 0, -128, 0};
        vecs[5] = '{0, 32767, 32767, 0, 0, 127, 0, 32767, 0, 256,     0, 32639, 0, 128};

        #12;
        checkValue("reset_out_valid", int'(out_valid0), 0);
        checkValue("reset_in_ready", int'(in_ready0), 1);
        checkValue("reset_y0_re", int'(y0_re0), 0);
        checkValue("reset_sat_flag", int'(sat0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: the capture edge counts as the first of three.
        applyVec(vecs[0]);
        in_valid = 1'b0;
        checkValue("latency_edge1", int'(out_valid0), 0);
        @(negedge clk);
        checkValue("latency_edge2", int'(out_valid0), 0);
        @(negedge clk);
        checkValue("latency_edge3", int'(out_valid0), 1);
        drain();

        applyVec(vecs[1]);
        in_valid = 1'b0;
        drain();
        checkValue("sat_flag_clear0", int'(sat0), 0);
        checkValue("sat_flag_clear1", int'(sat1), 0);

        applyVec(vecs[2]);
        in_valid = 1'b0;
        drain();
        checkValue("sat_flag_set", int'(sat0), 1);

        for (int i = 3; i < 6; i++) applyVec(vecs[i]);
        in_valid = 1'b0;
        drain();
        checkValue("sat_flag_held", int'(sat0), 1);
        checkValue("sat_flag_scaled", int'(sat1), 0);

        // Backpressure: 8 back-to-back sets, out_ready low for 4 cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    v.a_re = int'($urandom_range(65535)) - 32768;
                    v.a_im = int'($urandom_range(65535)) - 32768;
                    v.b_re = int'($urandom_range(65535)) - 32768;
                    v.b_im = int'($urandom_range(65535)) - 32768;
                    v.w_re = int'($urandom_range(4095)) - 2048;
                    v.w_im = int'($urandom_range(4095)) - 2048;
                    applyStimulus(v, model(v, 0), model(v, 1));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkValue("stall_out_valid", int'(out_valid0), 1);
                checkValue("stall_in_ready", int'(in_ready0), 0);
                cap = {out_valid0, y0_re0, y0_im0, y1_re0, y1_im0};
                repeat (3) begin
                    @(negedge clk);
                    checkValue("stall_in_ready", int'(in_ready0), 0);
                    checkValue("stall_hold",
                               int'(cap == {out_valid0, y0_re0, y0_im0, y1_re0, y1_im0}), 1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two sets in flight: everything clears at once.
        applyVec(vecs[0]);
        applyVec(vecs[3]);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkValue("rst_out_valid", int'(out_valid0), 0);
        checkValue("rst_y0_re", int'(y0_re0), 0);
        checkValue("rst_y1_re", int'(y1_re0), 0);
        checkValue("rst_y0_im", int'(y0_im0), 0);
        checkValue("rst_sat_flag", int'(sat0), 0);
        checkValue("rst_in_ready", int'(in_ready0), 1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        checkValue("rst_no_ghost", seen, 0);

        applyVec(vecs[4]);
        in_valid = 1'b0;
        drain();
        checkValue("post_rst_sat_flag", int'(sat0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
